// File: rtl/fir_filter_param.sv
// Coefficient-programmable direct-form FIR with one time-shared MAC.
// Samples in and results out over valid/ready; output is shifted and saturated.
module fir_filter_param #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic signed [DATA_W-1:0]   x_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [OUT_W-1:0]    y_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       sat,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + AW;
  localparam int EXT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic signed [EXT_W-1:0] OUT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] x_q    [TAPS];
  logic signed [DATA_W-1:0] x_d    [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [COEF_W-1:0] coef_d [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [AW-1:0]            k_q, k_d;
  logic signed [OUT_W-1:0]  y_q, y_d;
  logic                     sat_q, sat_d;

  logic signed [PROD_W-1:0] coef_ext, x_ext, prod;
  logic signed [ACC_W-1:0]  sum, shifted;
  logic signed [EXT_W-1:0]  ext;

  // Operands are sign-extended to the full product width so the multiply is exact.
  always_comb begin
    coef_ext = {{DATA_W{coef_q[k_q][COEF_W-1]}}, coef_q[k_q]};
    x_ext    = {{COEF_W{x_q[k_q][DATA_W-1]}}, x_q[k_q]};
    prod     = coef_ext * x_ext;
    sum      = acc_q + {{AW{prod[PROD_W-1]}}, prod};
    shifted  = sum >>> SHIFT;
    ext      = {{(EXT_W-ACC_W){shifted[ACC_W-1]}}, shifted};
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    coef_d  = coef_q;
    acc_d   = acc_q;
    k_d     = k_q;
    y_d     = y_q;
    sat_d   = sat_q;

    case (state_q)
      IDLE: begin
        if (coef_we && ({1'b0, coef_addr} < (AW+1)'(TAPS))) begin
          coef_d[coef_addr] = coef_wdata;
        end
        if (in_valid) begin
          x_d[0] = x_in;
          for (int i = 1; i < TAPS; i++) begin
            x_d[i] = x_q[i-1];
          end
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        if (k_q == AW'(TAPS-1)) begin
          if (ext > OUT_MAX) begin
            y_d   = {1'b0, {(OUT_W-1){1'b1}}};
            sat_d = 1'b1;
          end else if (ext < OUT_MIN) begin
            y_d   = {1'b1, {(OUT_W-1){1'b0}}};
            sat_d = 1'b1;
          end else begin
            y_d   = ext[OUT_W-1:0];
            sat_d = 1'b0;
          end
          acc_d   = sum;
          state_d = OUT;
        end else begin
          acc_d = sum;
          k_d   = k_q + AW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over any accept or handshake in the same cycle; coefficients survive.
    if (clear) begin
      for (int i = 0; i < TAPS; i++) begin
        x_d[i] = '0;
      end
      sat_d   = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= '0;
      end
      acc_q <= '0;
      k_q   <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      coef_q  <= coef_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign y_out     = y_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Scoreboard bench for fir_filter_param: a 4-tap unshifted instance and a
// 3-tap instance with SHIFT=2, driven with hand-computed directed vectors.
module tb_fir_filter_param;

  typedef struct {
    int y;
    int s;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              clear;
  logic signed [7:0] x_in;
  logic              in_valid, s_in_valid;
  logic              out_ready;
  logic              coef_we, s_coef_we;
  logic [1:0]        coef_addr;
  logic signed [7:0] coef_wdata;

  logic               in_ready, out_valid, sat;
  logic signed [15:0] y_out;
  logic               s_in_ready, s_out_valid, s_sat;
  logic signed [15:0] s_y_out;

  exp_t q_main[$];
  exp_t q_shift[$];
  int   checks = 0;
  int   passes = 0;

  fir_filter_param #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(16), .SHIFT(0)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
    .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready), .sat(sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
  );

  fir_filter_param #(.DATA_W(8), .COEF_W(8), .TAPS(3), .OUT_W(16), .SHIFT(2)) dut_s (
    .clk(clk), .reset(reset), .clear(clear),
    .x_in(x_in), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .y_out(s_y_out), .out_valid(s_out_valid), .out_ready(out_ready), .sat(s_sat),
    .coef_we(s_coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Monitors pop the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (q_main.size() == 0) begin
        checks++;
        $display("[TB] FAIL main unexpected output: got y_out %0d, expected no output", y_out);
      end else begin
        exp_t e;
        e = q_main.pop_front();
        checkOutput("main y_out", int'(y_out), e.y);
        checkOutput("main sat", int'(sat), e.s);
      end
    end
  end

  always @(negedge clk) begin
    if (s_out_valid && out_ready) begin
      if (q_shift.size() == 0) begin
        checks++;
        $display("[TB] FAIL shift unexpected output: got y_out %0d, expected no output", s_y_out);
      end else begin
        exp_t e;
        e = q_shift.pop_front();
        checkOutput("shift y_out", int'(s_y_out), e.y);
        checkOutput("shift sat", int'(s_sat), e.s);
      end
    end
  end

  task automatic waitOutput(input int sel, input int start);
    int cycles;
    cycles = start;
    while (!(sel != 0 ? s_out_valid : out_valid) && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput(sel != 0 ? "shift latency" : "main latency", cycles, sel != 0 ? 3 : 4);
    @(posedge clk);
  endtask

  task automatic applyStimulus(input int sel, input int x, input int ey, input int es);
    exp_t e;
    @(negedge clk);
    checkOutput("in_ready before accept", int'(sel != 0 ? s_in_ready : in_ready), 1);
    e.y = ey;
    e.s = es;
    x_in = 8'(x);
    if (sel != 0) begin
      q_shift.push_back(e);
      s_in_valid = 1'b1;
    end else begin
      q_main.push_back(e);
      in_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    s_in_valid = 1'b0;
    waitOutput(sel, 0);
  endtask

  task automatic writeCoef(input int sel, input int addr, input int val);
    @(negedge clk);
    coef_addr  = 2'(addr);
    coef_wdata = 8'(val);
    if (sel != 0) s_coef_we = 1'b1;
    else coef_we = 1'b1;
    @(negedge clk);
    coef_we   = 1'b0;
    s_coef_we = 1'b0;
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    exp_t e;
    reset = 1'b0; clear = 1'b0; x_in = '0;
    in_valid = 1'b0; s_in_valid = 1'b0; out_ready = 1'b1;
    coef_we = 1'b0; s_coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;

    #2;
    checkOutput("reset y_out", int'(y_out), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset sat", int'(sat), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after reset", int'(in_ready), 1);

    // Shifted 3-tap instance: floor rounding and out-of-range coefficient address.
    writeCoef(1, 0, 1);
    applyStimulus(1, -5, -2, 0);
    writeCoef(1, 3, 9);
    applyStimulus(1, 4, 1, 0);
    applyStimulus(1, -8, -2, 0);

    // Impulse/ramp.
    writeCoef(0, 0, 1);
    writeCoef(0, 1, 2);
    writeCoef(0, 2, 3);
    writeCoef(0, 3, 4);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 2, 4, 0);
    applyStimulus(0, 3, 10, 0);
    applyStimulus(0, 4, 20, 0);
    applyStimulus(0, 5, 30, 0);
    applyStimulus(0, 0, 34, 0);

    // Saturation in both directions.
    for (int i = 0; i < 4; i++) writeCoef(0, i, 127);
    pulseClear();
    applyStimulus(0, 127, 16129, 0);
    applyStimulus(0, 127, 32258, 0);
    applyStimulus(0, 127, 32767, 1);
    applyStimulus(0, 127, 32767, 1);
    applyStimulus(0, -128, 32131, 0);
    applyStimulus(0, -128, -254, 0);
    applyStimulus(0, -128, -32639, 0);
    applyStimulus(0, -128, -32768, 1);

    // Backpressure: hold OUT for six cycles while a second sample is offered.
    writeCoef(0, 0, 1);
    writeCoef(0, 1, 2);
    writeCoef(0, 2, 3);
    writeCoef(0, 3, 4);
    pulseClear();
    @(negedge clk);
    out_ready = 1'b0;
    x_in = 8'sd10;
    in_valid = 1'b1;
    e.y = 10; e.s = 0;
    q_main.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("backpressure latency", cnt, 4);
    x_in = 8'sd99;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("hold out_valid", int'(out_valid), 1);
      checkOutput("hold y_out", int'(y_out), 10);
      checkOutput("hold sat", int'(sat), 0);
      checkOutput("hold in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    checkOutput("no extra output after handshake", cnt, 0);

    // Coefficient write during MAC is ignored; the same write in IDLE lands.
    @(negedge clk);
    x_in = 8'sd1;
    in_valid = 1'b1;
    e.y = 21; e.s = 0;
    q_main.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    coef_addr = 2'd0;
    coef_wdata = 8'sd50;
    coef_we = 1'b1;
    repeat (2) @(negedge clk);
    coef_we = 1'b0;
    waitOutput(0, 2);
    applyStimulus(0, 2, 34, 0);
    writeCoef(0, 0, 50);
    applyStimulus(0, 3, 197, 0);

    // Clear at the second MAC cycle aborts and flushes the delay line.
    @(negedge clk);
    x_in = 8'sd7;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clear out_valid", int'(out_valid), 0);
    checkOutput("clear in_ready", int'(in_ready), 1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    checkOutput("no output after clear", cnt, 0);
    applyStimulus(0, 1, 50, 0);

    // Asynchronous reset in the middle of MAC wipes outputs and coefficients.
    @(negedge clk);
    x_in = 8'sd5;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("y_out before reset", int'(y_out), 50);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid reset y_out", int'(y_out), 0);
    checkOutput("mid reset out_valid", int'(out_valid), 0);
    checkOutput("mid reset sat", int'(sat), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after mid reset", int'(in_ready), 1);
    applyStimulus(0, 3, 0, 0);

    repeat (5) @(negedge clk);
    checkOutput("main scoreboard drained", q_main.size(), 0);
    checkOutput("shift scoreboard drained", q_shift.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fir_filter_param.md
# fir_filter_param

Parametrised, coefficient-programmable successor to `fir_filter`. It is a signed direct-form FIR with a `TAPS`-deep sample delay line and one time-shared multiply-accumulate unit. Samples enter over a valid/ready handshake and results leave over a valid/ready handshake. Output is scaled by an arithmetic right shift and saturated to `OUT_W`. It sits between the sample source and downstream processing, and its coefficients are loaded at run time by the control path.

## Interface
- `DATA_W`, 8, signed input sample width
- `COEF_W`, 8, signed coefficient width
- `TAPS`, 4, number of taps (2..64)
- `OUT_W`, 16, signed output width
- `SHIFT`, 0, arithmetic right shift applied to the accumulator before saturation
- `clk`  in  1  clock; all registers on rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `clear`  in  1  synchronous flush: zero delay line, abort computation
- `x_in`  in  DATA_W  signed input sample
- `in_valid`  in  1  `x_in` valid
- `in_ready`  out  1  block accepts a sample
- `y_out`  out  OUT_W  signed filtered output
- `out_valid`  out  1  `y_out` valid
- `out_ready`  in  1  consumer accepts `y_out`
- `sat`  out  1  `y_out` was clamped; qualified by `out_valid`
- `coef_we`  in  1  coefficient write strobe
- `coef_addr`  in  clog2(TAPS)  tap index
- `coef_wdata`  in  COEF_W  signed coefficient value

## Operation
- Accumulator width is `ACC_W = DATA_W+COEF_W+clog2(TAPS)`. Products are signed full-width and sign-extended into the accumulator; no overflow is possible inside the accumulator.
- The FSM has three states: IDLE, MAC and OUT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: `x[0]` ← `x_in` and `x[k]` ← `x[k-1]` for all k.
  - On the same edge: acc ← 0, k ← 0, → MAC.
- **MAC**
  - One product per cycle: acc ← acc + `coef[k]`·`x[k]`, for k = 0..TAPS-1.
  - On the edge that adds k=TAPS-1, the final sum is computed as `(acc+prod)>>>SHIFT` and saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - That result is registered into `y_out`, with `sat` set if it was clamped; → OUT.
- **OUT**
  - `out_valid`=1; `y_out` and `sat` are held stable.
  - On `out_ready`: → IDLE and `out_valid` drops.
- Result: y[n] = Σ `coef[k]`·x[n-k], truncated by `SHIFT` (floor), then saturated.
- Coefficient writes:
  - Take effect on the `coef_we` edge only in IDLE.
  - Writes in MAC or OUT are ignored.
  - Writes with `coef_addr` ≥ `TAPS` are ignored.
- `clear`:
  - In any state, zeroes the delay line, forces IDLE and drops `out_valid`/`sat`.
  - Coefficients are retained.
  - `clear` takes priority over a same-cycle input accept or output handshake.
- Reset (asynchronous, mid-operation included): immediately forces all of the following.
  - FSM to IDLE.
  - Delay line, coefficients, acc and `y_out` to 0.
  - `out_valid`=0 and `sat`=0.
  - `in_ready` is 1 after reset deasserts.

## Timing
- Reset values: `in_ready`=1 (once deasserted), `out_valid`=0, `y_out`=0, `sat`=0.
- Accept at edge E0 → MAC edges E1..E_TAPS → `out_valid` high from after E_TAPS.
- Latency is therefore TAPS cycles from accept to `out_valid`.
- With `out_ready` held at 1, the handshake occurs at E_TAPS+1 and the next accept is possible at E_TAPS+2. Sustained throughput is one sample per TAPS+2 cycles.
- `in_ready` is 0 throughout MAC and OUT. `in_valid` while `in_ready`=0 is ignored; the source must hold its sample.
- Backpressure: with `out_ready`=0, OUT is held indefinitely with no data loss.

## Test plan
- **Impulse/ramp:** TAPS=4, coefs {1,2,3,4}, SHIFT=0, inputs 1,2,3,4,5,0 → `y_out` 1,4,10,20,30,34, each appearing 4 cycles after its accept.
- **Saturation:**
  - All coefs 127, four inputs of 127 → last `y_out`=32767 with `sat`=1.
  - All coefs 127, four inputs of -128 → `y_out`=-32768 with `sat`=1.
- **Shift:** SHIFT=2, coefs {1,0,0,0}, input -5 → `y_out`=-2 (floor), `sat`=0.
- **Backpressure:** `out_ready`=0 for 6 cycles during OUT → `out_valid`, `y_out` and `sat` stable; `in_ready`=0; no extra sample accepted; exactly one handshake occurs once `out_ready` rises.
- **Coefficient gating:**
  - A write to tap 0 during MAC is ignored, so the current and next results use the old value.
  - The same write issued in IDLE is applied.
  - `coef_addr`=TAPS is ignored.
- **Abort:**
  - `clear` at MAC cycle 2 → IDLE the next cycle, `out_valid` never asserted; the next input 1 yields `y_out`=`coef[0]`.
  - `reset`=0 mid-MAC → outputs 0 immediately and coefs 0, so subsequent `y_out`=0.
